lsu_mem_access: RTL and testbench
=================================

// Module: lsu_mem_access
// PURPOSE
//  Execution/memory side of the load/store unit: consumes one decoded LSU op
//  (is_load, zero_ext, is_nop, size, rd, imm) plus operand values, then computes the address.
//  Drives a valid/ready memory request with byte-lane steering; for loads it extracts and
//  sign/zero-extends the response and emits one register write-back. One op in flight.
// PARAMETERS
//  ADDR_W  32  byte-address width (rs1_val and mem_addr width)
//  DATA_W  32  memory data width; only 32 supported (4 byte lanes)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       reset, asynchronous, active-high
//  op_valid       in   1       decoded LSU op present
//  op_ready       out  1       unit can accept an op (IDLE only)
//  is_load        in   1       1=load, 0=store
//  zero_ext       in   1       1=LBU/LHU zero-extend
//  is_nop         in   1       op is a NOP; accepted, no effect
//  size           in   2       0=byte,1=half,2=word,3=treated as word
//  rd             in   5       load destination register
//  imm            in   12      signed offset
//  rs1_val        in   ADDR_W  base address operand
//  rs2_val        in   DATA_W  store data operand
//  mem_req_valid  out  1       memory request valid
//  mem_req_ready  in   1       memory accepts request
//  mem_we         out  1       1=write
//  mem_addr       out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  mem_be         out  4       byte enables
//  mem_wdata      out  DATA_W  lane-replicated store data
//  mem_rsp_valid  in   1       load data valid (one cycle)
//  mem_rsp_rdata  in   DATA_W  load data, full word
//  wb_valid       out  1       one-cycle write-back pulse
//  wb_rd          out  5       write-back register
//  wb_data        out  DATA_W  extended load result
//  misalign       out  1       one-cycle pulse: op dropped, address misaligned
// BEHAVIOUR
//  - Reset: FSM=IDLE, op_ready=1; every other output 0. Reset mid-op aborts the op; no replay.
//  - FSM: IDLE -> REQ on accepted load/store; IDLE -> IDLE on NOP; IDLE -> ERR on misaligned.
//    ERR -> IDLE after 1 cycle. REQ -> IDLE on handshake if store. REQ -> WAIT on handshake if load.
//    WAIT -> WB on mem_rsp_valid. WB -> IDLE after 1 cycle.
//  - Accept when op_valid&&op_ready; all fields registered on that edge.
//  - addr = rs1_val + sign_extend(imm), modulo 2^ADDR_W (wraps, no flag).
//  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//    misalign=1 for the ERR cycle; no memory request; no write-back.
//  - mem_req_valid=1 throughout REQ. While it is held without ready, we/addr/be/wdata stay stable.
//  - Byte lanes:
//    - byte: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
//    - half: be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
//    - word: be=4'hF, wdata=rs2.
//    - Loads drive the same be with we=0 and wdata=0.
//  - Stores are posted: no response awaited; done at handshake.
//  - Load extract: lane=rdata>>(8*addr[1:0]).
//    - byte: lane[7:0] extended; half: lane[15:0] extended; word: rdata.
//    - Extension is sign unless zero_ext=1.
//  - WB: wb_valid=1 for exactly one cycle with wb_rd=rd and wb_data registered.
//    Fires even when rd=0; the register file ignores x0.
//  - mem_rsp_valid outside WAIT is ignored, including stale responses after reset.
//  - Same-cycle rsp and handshake are impossible (WAIT is entered only after the handshake).
//  - Latency: load accepted at T -> req at T+1; rsp at T+2 at the earliest -> wb_valid at T+3.
//    Store accepted at T -> req at T+1 -> op_ready at T+2 at the earliest.
// STRUCTURE
//  - lsu_pkg: lsu_size_e {LSU_B=0,LSU_H=1,LSU_W=2}; lsu_state_e {IDLE,REQ,WAIT,WB,ERR}.
//    Also OPC_LOAD=7'b0000011 and OPC_STORE=7'b0100011, shared with the decoder.
//  - Sub-module lsu_align (combinational): takes size, addr[1:0], rs2, rdata and zero_ext.
//    Produces be, wdata, extended load data and misaligned flag.
// TESTING
//  1. SW rs1=0x1004 imm=0xFFC rs2=0xDEADBEEF -> mem_addr=0x1000 be=4'hF wdata=0xDEADBEEF we=1.
//     Expect no wb_valid.
//  2. SB rs1=0x1003 imm=0 rs2=0x000000A5 -> be=4'b1000 wdata=0xA5A5A5A5.
//  3. LB/LBU addr=0x1001 rdata=0x123480FF -> wb_data 0xFFFFFF80 / 0x00000080.
//     wb_valid 3 cycles after accept.
//  4. LH/LHU addr=0x1002 rdata=0x8001_7777 -> wb_data 0xFFFF8001 / 0x00008001, be=4'b1100.
//  5. LW addr=0x1002 -> misalign pulse 1 cycle, mem_req_valid never 1, op_ready=1 two cycles later.
//     A NOP is accepted with no outputs.
//  6. Hold mem_req_ready=0 for 3 cycles -> request fields stable.
//     Then assert rst in WAIT -> all outputs 0 immediately; a later mem_rsp_valid gives no wb_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The opcodes are also used by the decoder.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_B = 2'd0,
    LSU_H = 2'd1,
    LSU_W = 2'd2
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    WB   = 3'd3,
    ERR  = 3'd4
  } lsu_state_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // A size code of 3 is handled as a word, so size[1] alone selects word checks.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == LSU_H) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Memory-side request/response bus between the LSU (master) and the memory (slave).
interface lsu_mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads on a 32-bit bus.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  input  logic        zero_ext,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [31:0] lane;

  always_comb begin
    lane       = rdata >> {off, 3'b000};
    be         = 4'hF;
    wdata      = rs2;
    ld_data    = lane;
    misaligned = lsu_misaligned(size, off);
    case (size)
      LSU_B: begin
        be      = 4'b0001 << off;
        wdata   = {4{rs2[7:0]}};
        ld_data = {{24{~zero_ext & lane[7]}}, lane[7:0]};
      end
      LSU_H: begin
        be      = 4'b0011 << off;
        wdata   = {2{rs2[15:0]}};
        ld_data = {{16{~zero_ext & lane[15]}}, lane[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// LSU execution/memory stage: address generation, memory request, load write-back.
//   state | meaning
//   IDLE  | ready for a new op
//   REQ   | memory request held until mem_req_ready
//   WAIT  | load issued, waiting for mem_rsp_valid
//   WB    | one-cycle write-back pulse
//   ERR   | one-cycle misalign pulse, op dropped
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              is_load,
  input  logic              zero_ext,
  input  logic              is_nop,
  input  logic [1:0]        size,
  input  logic [4:0]        rd,
  input  logic [11:0]       imm,
  input  logic [ADDR_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  lsu_mem_access_if.master  mem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);

  lsu_state_e        state_q, state_d;
  logic              capture;
  logic              is_load_q, zero_ext_q;
  logic [1:0]        size_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rs2_q, wb_data_q;
  logic              in_idle, in_req;
  logic [1:0]        al_size, al_off;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata, al_ld;
  logic              al_mis;

  assign addr_d  = rs1_val + {{(ADDR_W-12){imm[11]}}, imm};
  assign in_idle = (state_q == IDLE);
  assign in_req  = (state_q == REQ);

  // In IDLE the aligner checks the incoming op; afterwards it works on the captured op.
  assign al_size = in_idle ? size        : size_q;
  assign al_off  = in_idle ? addr_d[1:0] : addr_q[1:0];

  lsu_align u_align (
    .size       (al_size),
    .off        (al_off),
    .rs2        (rs2_q),
    .rdata      (mem.mem_rsp_rdata),
    .zero_ext   (zero_ext_q),
    .be         (al_be),
    .wdata      (al_wdata),
    .ld_data    (al_ld),
    .misaligned (al_mis)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid && !is_nop) begin
          if (al_mis) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            capture = 1'b1;
          end
        end
      end
      REQ:     if (mem.mem_req_ready) state_d = is_load_q ? WAIT : IDLE;
      WAIT:    if (mem.mem_rsp_valid) state_d = WB;
      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_load_q  <= 1'b0;
      zero_ext_q <= 1'b0;
      size_q     <= 2'd0;
      rd_q       <= 5'd0;
      addr_q     <= '0;
      rs2_q      <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        is_load_q  <= is_load;
        zero_ext_q <= zero_ext;
        size_q     <= size;
        rd_q       <= rd;
        addr_q     <= addr_d;
        rs2_q      <= rs2_val;
      end
      if ((state_q == WAIT) && mem.mem_rsp_valid) wb_data_q <= al_ld;
    end
  end

  assign op_ready          = in_idle;
  assign mem.mem_req_valid = in_req;
  assign mem.mem_we        = in_req & ~is_load_q;
  assign mem.mem_addr      = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem.mem_be        = in_req ? al_be : 4'h0;
  assign mem.mem_wdata     = (in_req && !is_load_q) ? al_wdata : '0;
  assign wb_valid          = (state_q == WB);
  assign wb_rd             = wb_valid ? rd_q : 5'd0;
  assign wb_data           = wb_valid ? wb_data_q : '0;
  assign misalign          = (state_q == ERR);

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: stores, loads, misalign, NOP, stall and reset abort.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready, is_load, zero_ext, is_nop;
  logic [1:0]  size;
  logic [4:0]  rd, wb_rd;
  logic [11:0] imm;
  logic [31:0] rs1_val, rs2_val, wb_data;
  logic        wb_valid, misalign;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_mem_access_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  lsu_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .is_load  (is_load),
    .zero_ext (zero_ext),
    .is_nop   (is_nop),
    .size     (size),
    .rd       (rd),
    .imm      (imm),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .mem      (mem_if),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic ld, input logic zx, input logic nop, input logic [1:0] sz,
                        input logic [4:0] rdi, input logic [31:0] rs1, input logic [11:0] im,
                        input logic [31:0] rs2);
    op_valid = 1'b1; is_load = ld; zero_ext = zx; is_nop = nop; size = sz;
    rd = rdi; rs1_val = rs1; imm = im; rs2_val = rs2;
    tick();
    op_valid = 1'b0; is_nop = 1'b0;
  endtask

  // Load with ready already high: REQ, WAIT (response), WB, back to IDLE.
  task automatic run_load(input string tag, input logic zx, input logic [1:0] sz, input logic [31:0] rs1,
                          input logic [4:0] rdi, input logic [31:0] rdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wb);
    mem_if.mem_req_ready = 1'b1;
    accept(1'b1, zx, 1'b0, sz, rdi, rs1, 12'h000, 32'hCAFEF00D);
    chk({tag, "_req"}, {mem_if.mem_req_valid, mem_if.mem_we, mem_if.mem_be}, {26'd0, 1'b1, 1'b0, exp_be});
    chk({tag, "_addr"}, mem_if.mem_addr, exp_addr);
    chk({tag, "_wdata0"}, mem_if.mem_wdata, 32'h0);
    tick();
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_rdata = rdata;
    chk({tag, "_wait_nowb"}, {31'd0, wb_valid}, 32'd0);
    tick();
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = 32'h0;
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, rdi});
    chk({tag, "_wb_data"}, wb_data, exp_wb);
    tick();
    chk({tag, "_done"}, {30'd0, wb_valid, op_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    op_valid = 1'b0; is_load = 1'b0; zero_ext = 1'b0; is_nop = 1'b0;
    size = 2'd0; rd = 5'd0; imm = 12'h0; rs1_val = 32'h0; rs2_val = 32'h0;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_rsp_valid = 1'b0; mem_if.mem_rsp_rdata = 32'h0;
    tick(); tick();
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_outs", {27'd0, mem_if.mem_req_valid, mem_if.mem_we, wb_valid, misalign, |mem_if.mem_be}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, op_ready}, 32'd1);

    // SW: 0x1004 + (-4) = 0x1000, held one cycle without ready first
    accept(1'b0, 1'b0, 1'b0, 2'd2, 5'd3, 32'h0000_1004, 12'hFFC, 32'hDEAD_BEEF);
    chk("sw_req", {28'd0, mem_if.mem_req_valid, mem_if.mem_we, op_ready, wb_valid}, 32'b1100);
    chk("sw_addr", mem_if.mem_addr, 32'h0000_1000);
    chk("sw_be", {28'd0, mem_if.mem_be}, 32'hF);
    chk("sw_wdata", mem_if.mem_wdata, 32'hDEAD_BEEF);
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    chk("sw_done", {29'd0, op_ready, mem_if.mem_req_valid, wb_valid}, 32'b100);

    // SB to the top byte lane
    accept(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0000_1003, 12'h000, 32'h0000_00A5);
    chk("sb_be", {28'd0, mem_if.mem_be}, 32'b1000);
    chk("sb_wdata", mem_if.mem_wdata, 32'hA5A5_A5A5);
    chk("sb_addr", mem_if.mem_addr, 32'h0000_1000);
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    chk("sb_done", {31'd0, op_ready}, 32'd1);

    // SH with address wrap: 0xFFFFFFFF + 3 = 0x2
    accept(1'b0, 1'b0, 1'b0, 2'd1, 5'd0, 32'hFFFF_FFFF, 12'h003, 32'h1234_BEEF);
    chk("sh_wrap_addr", mem_if.mem_addr, 32'h0000_0000);
    chk("sh_wrap_be", {28'd0, mem_if.mem_be}, 32'b1100);
    chk("sh_wrap_wdata", mem_if.mem_wdata, 32'hBEEF_BEEF);
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;

    run_load("lb",  1'b0, 2'd0, 32'h0000_1001, 5'd5,  32'h1234_80FF, 4'b0010, 32'h0000_1000, 32'hFFFF_FF80);
    run_load("lbu", 1'b1, 2'd0, 32'h0000_1001, 5'd6,  32'h1234_80FF, 4'b0010, 32'h0000_1000, 32'h0000_0080);
    run_load("lh",  1'b0, 2'd1, 32'h0000_1002, 5'd7,  32'h8001_7777, 4'b1100, 32'h0000_1000, 32'hFFFF_8001);
    run_load("lhu", 1'b1, 2'd1, 32'h0000_1002, 5'd8,  32'h8001_7777, 4'b1100, 32'h0000_1000, 32'h0000_8001);
    run_load("lw3", 1'b0, 2'd3, 32'h0000_2008, 5'd0,  32'h8001_7777, 4'b1111, 32'h0000_2008, 32'h8001_7777);

    // Misaligned LW: one misalign cycle, no request
    mem_if.mem_req_ready = 1'b1;
    accept(1'b1, 1'b0, 1'b0, 2'd2, 5'd9, 32'h0000_1002, 12'h000, 32'h0);
    chk("lw_mis_pulse", {29'd0, misalign, mem_if.mem_req_valid, op_ready}, 32'b100);
    tick();
    chk("lw_mis_after", {29'd0, misalign, mem_if.mem_req_valid, op_ready}, 32'b001);
    // Misaligned SH (odd address)
    accept(1'b0, 1'b0, 1'b0, 2'd1, 5'd0, 32'h0000_1001, 12'h000, 32'h0);
    chk("sh_mis_pulse", {30'd0, misalign, mem_if.mem_req_valid}, 32'b10);
    tick();
    // NOP accepted with no effect
    accept(1'b1, 1'b0, 1'b1, 2'd2, 5'd1, 32'h0000_1000, 12'h000, 32'h0);
    chk("nop_outs", {28'd0, op_ready, mem_if.mem_req_valid, misalign, wb_valid}, 32'b1000);
    mem_if.mem_req_ready = 1'b0;

    // Load held without ready for 3 cycles, then reset while in WAIT
    accept(1'b1, 1'b0, 1'b0, 2'd2, 5'd10, 32'h0000_1FF0, 12'h010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {27'd0, mem_if.mem_req_valid, mem_if.mem_we, mem_if.mem_be}, {27'd0, 1'b1, 1'b0, 4'hF});
      chk("stall_addr", mem_if.mem_addr, 32'h0000_2000);
      tick();
    end
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    chk("wait_state", {30'd0, mem_if.mem_req_valid, op_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {27'd0, op_ready, mem_if.mem_req_valid, wb_valid, misalign, mem_if.mem_we}, 32'b10000);
    tick();
    rst = 1'b0;
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_rdata = 32'h5555_AAAA;
    tick();
    mem_if.mem_rsp_valid = 1'b0;
    chk("stale_rsp", {30'd0, wb_valid, op_ready}, 32'b01);
    tick();
    chk("stale_rsp2", {31'd0, wb_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
